// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
// Groups the req/ack fetch bus so the fetch stage and the memory agree on one
// bundle.
//   imem_req   : fetch request, driven by the fetch stage
//   imem_addr  : word-aligned fetch address, driven by the fetch stage
//   imem_rdata : instruction word, driven by memory, valid when imem_ack=1
//   imem_ack   : response strobe, driven by memory; may rise in the request cycle
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    // Fetch-stage side of the bus.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    // Memory side of the bus.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the pipelined CPU.
// Owns the program counter and picks the next PC from the sequential, branch,
// register or jump source. It fetches through a req/ack memory port that may
// insert any number of wait states. It loads the fetched instruction and its
// PC+4 into the IF/ID register read by decode. When decode is stalled in the
// cycle the memory answers, a one-entry hold buffer keeps the response until
// the stall clears.
// Ports:
//   clk      : clock, all state changes on posedge
//   clrn     : synchronous active-low reset
//   stall    : decode stall, freezes pc and IF/ID
//   pcsource : next-PC select (00 pc+4, 01 bpc, 10 rpc, 11 jpc)
//   bpc/rpc/jpc : redirect targets from decode
//   imem     : instruction-memory bus (master side)
//   pc       : current program counter
//   id_ins / id_pc4 / id_valid : IF/ID pipeline register
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    if_fetch_stage_if.master imem,
    output logic [31:0] pc,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] buf_ins;
    logic [31:0] buf_pc4;
    logic [31:0] pc4;
    logic [31:0] seq_pc;
    logic [31:0] npc_sel;
    logic [31:0] npc;

    // The request comes only from the state register, so it never depends on
    // this cycle's ack or rdata. The address is the PC itself. It stays
    // constant while the fetch waits, because pc changes only on a response.
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;

    // Next-PC selection. In HOLD the sequential successor comes from the
    // buffered PC+4. That value always equals pc+4, because pc does not move
    // while the stage holds. The target is masked to a word boundary, and the
    // add wraps modulo 2^32.
    always_comb begin
        pc4    = pc + 32'd4;
        seq_pc = (state == HOLD) ? buf_pc4 : pc4;
        case (pcsource)
            2'b00:   npc_sel = seq_pc;
            2'b01:   npc_sel = bpc;
            2'b10:   npc_sel = rpc;
            default: npc_sel = jpc;
        endcase
        npc = npc_sel & 32'hFFFF_FFFC;
    end

    // Fetch control and the IF/ID register. pcsource and the targets are read
    // only on a cycle that moves pc. Every other cycle either holds or, for a
    // memory wait without a stall, sends a bubble into decode. Reset drops any
    // outstanding fetch, and an ack in the reset cycle is ignored.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            id_ins   <= 32'h0;
            id_pc4   <= 32'h0;
            id_valid <= 1'b0;
            buf_ins  <= 32'h0;
            buf_pc4  <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        if (!stall) begin
                            id_ins   <= imem.imem_rdata;
                            id_pc4   <= pc4;
                            id_valid <= 1'b1;
                            pc       <= npc;
                        end else begin
                            buf_ins  <= imem.imem_rdata;
                            buf_pc4  <= pc4;
                            state    <= HOLD;
                        end
                    end else if (!stall) begin
                        id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_ins   <= buf_ins;
                        id_pc4   <= buf_pc4;
                        id_valid <= 1'b1;
                        pc       <= npc;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined CPU. Owns the 32-bit program counter, selects the next PC from sequential/branch/register/jump sources, fetches through a req/ack instruction-memory port with arbitrary wait states, and delivers the fetched instruction plus PC+4 into the IF/ID pipeline register consumed by decode. A one-entry hold buffer absorbs a memory response that arrives while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset (word aligned)
- clk  in  1  clock, all state updates on posedge
- clrn  in  1  synchronous active-low reset, sampled on posedge clk
- stall  in  1  decode stall; 1 = IF/ID outputs and PC must hold
- pcsource  in  2  next-PC select: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
- bpc, rpc, jpc  in  32 each  branch / register / jump targets from decode
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- imem_ack  in  1  response strobe; may assert in the same cycle as imem_req (zero wait)
- pc  out  32  current PC
- id_ins  out  32  IF/ID instruction
- id_pc4  out  32  IF/ID PC+4 of that instruction
- id_valid  out  1  IF/ID valid; 0 = bubble

## Operation
- States: FETCH, HOLD. Reset -> FETCH.
- npc = pcsource-selected value; 00 gives pc+4 (HOLD: buffered pc4). Arithmetic modulo 2^32 (0xFFFF_FFFC + 4 = 0). npc[1:0] forced to 00.
- FETCH: imem_req=1, imem_addr=pc, held stable until ack.
  - ack & !stall: id_ins<=imem_rdata, id_pc4<=pc+4, id_valid<=1, pc<=npc; stay FETCH.
  - ack & stall: buf_ins<=imem_rdata, buf_pc4<=pc+4; ID regs and pc hold; -> HOLD.
  - !ack & !stall: id_valid<=0 (bubble), id_ins/id_pc4 hold; pc holds.
  - !ack & stall: everything holds.
- HOLD: imem_req=0.
  - stall: hold.
  - !stall: id_ins<=buf_ins, id_pc4<=buf_pc4, id_valid<=1, pc<=npc; -> FETCH.
- pcsource and targets are sampled only on the cycle pc updates; delayed-branch architecture, no flush of the fetched slot.
- imem_req must not depend combinationally on imem_ack or imem_rdata.
- Reset (clrn=0 at posedge): pc<=RESET_PC, state<=FETCH, id_ins<=0, id_pc4<=0, id_valid<=0, hold buffer cleared; imem_ack in that cycle is ignored. Reset mid-wait abandons the outstanding fetch; memory model must drop it.

## Timing
- Reset values: pc=RESET_PC, id_ins=0, id_pc4=0, id_valid=0, imem_req=1 (FETCH) once clrn=1, imem_addr=RESET_PC.
- Zero-wait memory: one instruction per cycle; ID sees instruction at addr A one cycle after A is presented.
- N wait states: N bubbles (id_valid=0) into ID, instruction appears cycle after ack.
- Stall during ack: instruction enters ID the cycle after stall drops; next fetch request begins that same cycle (1 cycle without imem_req).
- Redirect latency: target appears on imem_addr the cycle after the update cycle that sampled pcsource!=00.

## Test plan
- Reset then zero-wait memory returning word = address: id_ins sequence 0x0,0x4,0x8 on cycles 2,3,4 after clrn rises; id_pc4 = id_ins+4; id_valid=1 throughout.
- Memory with 2 wait states: id_valid pattern 0,0,1 repeating; pc advances by 4 only on ack cycles.
- Ack at pc=0x10 with stall held 3 cycles: ID holds previous instruction, imem_req=0 for 3 cycles, then id_ins=mem[0x10], pc=0x14.
- pcsource=01, bpc=0x0000_0102 at the update cycle: next imem_addr=0x0000_0100; pcsource=10/11 likewise select rpc/jpc.
- RESET_PC=0xFFFF_FFFC, pcsource=00: after first ack pc=0x0000_0000, id_pc4=0x0000_0000.
- Assert clrn=0 while waiting for ack (ack arrives in reset cycle): id_valid=0, pc=RESET_PC, no instruction captured; fetching restarts at RESET_PC.
